// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect sequencer.
package fetch_ctrl_pkg;

    // Sequencer states: normal streaming, redirect strobe, waiting for refill
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_REFILL   = 2'd2
    } fetch_state_e;

    // Redirect source; numeric order is the arbitration priority
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } redirect_src_e;

    localparam int unsigned REDIRECT_CNT_W = 16;
    localparam int unsigned RETRY_CNT_W    = 8;
    localparam int unsigned REFILL_CNT_W   = 8;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Request / fetch / decode signal bundle for fetch_redirect_ctrl.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface fetch_redirect_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    import fetch_ctrl_pkg::*;

    logic                      trap_valid;
    logic [ADDRESS_WIDTH-1:0]  trap_addr;
    logic                      br_valid;
    logic [ADDRESS_WIDTH-1:0]  br_addr;
    logic                      jmp_valid;
    logic [ADDRESS_WIDTH-1:0]  jmp_addr;
    logic                      dec_ready;
    logic                      fetch_empty;
    logic                      jump_branch_valid;
    logic [ADDRESS_WIDTH-1:0]  jump_branch_address;
    logic                      Read_enable;
    logic                      inst_valid;
    logic                      flush_out;
    logic                      busy;
    logic [REDIRECT_CNT_W-1:0] redirect_count;
    logic [RETRY_CNT_W-1:0]    retry_count;

    modport slave (
        input  trap_valid, trap_addr, br_valid, br_addr, jmp_valid, jmp_addr,
        input  dec_ready, fetch_empty,
        output jump_branch_valid, jump_branch_address, Read_enable, inst_valid,
        output flush_out, busy, redirect_count, retry_count
    );

    modport master (
        output trap_valid, trap_addr, br_valid, br_addr, jmp_valid, jmp_addr,
        output dec_ready, fetch_empty,
        input  jump_branch_valid, jump_branch_address, Read_enable, inst_valid,
        input  flush_out, busy, redirect_count, retry_count
    );

endinterface

// File: rtl/fetch_redirect_ctrl_arbiter.sv
// Fixed-priority (trap > branch > jump) redirect request encoder.
module redirect_arbiter
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     i_trap_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_trap_addr,
    input  logic                     i_br_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_br_addr,
    input  logic                     i_jmp_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_jmp_addr,
    output logic                     o_any_valid,
    output redirect_src_e            o_source,
    output logic [ADDRESS_WIDTH-1:0] o_addr
);

    // Pick the highest-priority active request and its target
    always_comb begin
        o_any_valid = 1'b0;
        o_source    = SRC_NONE;
        o_addr      = '0;
        if (i_trap_valid) begin
            o_any_valid = 1'b1;
            o_source    = SRC_TRAP;
            o_addr      = i_trap_addr;
        end else if (i_br_valid) begin
            o_any_valid = 1'b1;
            o_source    = SRC_BR;
            o_addr      = i_br_addr;
        end else if (i_jmp_valid) begin
            o_any_valid = 1'b1;
            o_source    = SRC_JMP;
            o_addr      = i_jmp_addr;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Redirect and stall sequencer for the instruction fetch unit.
// Optional statistics counters enabled by defining FETCH_REDIRECT_STATS_EN;
// otherwise redirect_count/retry_count are tied to zero.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned REFILL_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_redirect_ctrl_if.slave bus
);

    fetch_state_e              r_state;
    fetch_state_e              w_next_state;
    redirect_src_e             r_src;
    redirect_src_e             w_arb_src;
    logic [ADDRESS_WIDTH-1:0]  r_target;
    logic [ADDRESS_WIDTH-1:0]  w_arb_addr;
    logic                      w_arb_valid;
    logic                      w_accept;
    logic                      w_timeout;
    logic [REFILL_CNT_W-1:0]   r_refill_cnt;
    logic                      r_jb_valid;
    logic [ADDRESS_WIDTH-1:0]  r_jb_address;
    logic                      r_flush;
    logic                      r_busy;

    redirect_arbiter #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_arbiter (
        .i_trap_valid(bus.trap_valid),
        .i_trap_addr (bus.trap_addr),
        .i_br_valid  (bus.br_valid),
        .i_br_addr   (bus.br_addr),
        .i_jmp_valid (bus.jmp_valid),
        .i_jmp_addr  (bus.jmp_addr),
        .o_any_valid (w_arb_valid),
        .o_source    (w_arb_src),
        .o_addr      (w_arb_addr)
    );

    // Request acceptance and refill timeout detection
    always_comb begin
        w_accept  = w_arb_valid && ((r_state == ST_RUN) || (w_arb_src >= r_src));
        w_timeout = (r_state == ST_REFILL) && bus.fetch_empty &&
                    (r_refill_cnt == REFILL_CNT_W'(REFILL_TIMEOUT));
    end

    // Next-state logic; an accepted request always restarts the redirect
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = ST_REDIRECT;
        end else begin
            case (r_state)
                ST_RUN:      w_next_state = ST_RUN;
                ST_REDIRECT: w_next_state = ST_REFILL;
                ST_REFILL: begin
                    if (!bus.fetch_empty) begin
                        w_next_state = ST_RUN;
                    end else if (w_timeout) begin
                        w_next_state = ST_REDIRECT;
                    end
                end
                default:     w_next_state = ST_RUN;
            endcase
        end
    end

    // State, latched redirect, refill counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_src        <= SRC_NONE;
            r_target     <= '0;
            r_refill_cnt <= '0;
            r_jb_valid   <= 1'b0;
            r_jb_address <= '0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_src    <= w_arb_src;
                r_target <= w_arb_addr;
            end
            if (r_state == ST_REDIRECT) begin
                r_refill_cnt <= '0;
            end else if (r_state == ST_REFILL) begin
                r_refill_cnt <= r_refill_cnt + 1'b1;
            end
            // Outputs are registered from next-state so they align with the state they describe
            r_jb_valid   <= (w_next_state == ST_REDIRECT);
            r_flush      <= (w_next_state == ST_REDIRECT);
            r_busy       <= (w_next_state != ST_RUN);
            r_jb_address <= w_accept ? w_arb_addr : r_target;
        end
    end

    assign bus.jump_branch_valid   = r_jb_valid;
    assign bus.jump_branch_address = r_jb_address;
    assign bus.flush_out           = r_flush;
    assign bus.busy                = r_busy;
    assign bus.Read_enable         = (r_state == ST_RUN) && bus.dec_ready && !bus.fetch_empty;
    assign bus.inst_valid          = (r_state == ST_RUN) && bus.dec_ready && !bus.fetch_empty;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [REDIRECT_CNT_W-1:0] r_redirect_count;
    logic [RETRY_CNT_W-1:0]    r_retry_count;

    // Saturating statistics; a retry only counts when no new request overrides it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_count <= '0;
            r_retry_count    <= '0;
        end else begin
            if (w_accept && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
            if (w_timeout && !w_accept && (r_retry_count != '1)) begin
                r_retry_count <= r_retry_count + 1'b1;
            end
        end
    end

    assign bus.redirect_count = r_redirect_count;
    assign bus.retry_count    = r_retry_count;
`else
    assign bus.redirect_count = '0;
    assign bus.retry_count    = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (REFILL_TIMEOUT=8).
module tb_fetch_redirect_ctrl;
    import fetch_ctrl_pkg::*;

`ifdef FETCH_REDIRECT_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_redirect_ctrl_if #(.ADDRESS_WIDTH(32)) bus ();

    fetch_redirect_ctrl #(
        .ADDRESS_WIDTH (32),
        .REFILL_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.trap_valid = 1'b0;
        bus.br_valid   = 1'b0;
        bus.jmp_valid  = 1'b0;
        bus.trap_addr  = '0;
        bus.br_addr    = '0;
        bus.jmp_addr   = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        bus.dec_ready   = 1'b1;
        bus.fetch_empty = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        bus.dec_ready   = 1'b1;
        bus.fetch_empty = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL reset_jbv got=%0b exp=0", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h0) begin bad++; $display("FAIL reset_jba got=%0h exp=0", bus.jump_branch_address); end
        total++; if (bus.flush_out !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", bus.flush_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL reset_re got=%0b exp=0", bus.Read_enable); end
        total++; if (bus.redirect_count !== 16'd0) begin bad++; $display("FAIL reset_rcnt got=%0d exp=0", bus.redirect_count); end
        total++; if (bus.retry_count !== 8'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_count); end
        reset = 1'b0;
    endtask

    task automatic test_run_stream();
        do_reset();
        bus.fetch_empty = 1'b0;
        bus.dec_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.Read_enable !== 1'b1) begin bad++; $display("FAIL run_re[%0d] got=%0b exp=1", i, bus.Read_enable); end
            total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL run_iv[%0d] got=%0b exp=1", i, bus.inst_valid); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL run_busy[%0d] got=%0b exp=0", i, bus.busy); end
        end
        total++; if (bus.redirect_count !== 16'd0) begin bad++; $display("FAIL run_rcnt got=%0d exp=0", bus.redirect_count); end
        bus.dec_ready = 1'b0;
        #1;
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL run_stall_re got=%0b exp=0", bus.Read_enable); end
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL run_stall_iv got=%0b exp=0", bus.inst_valid); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL run_stall_busy got=%0b exp=0", bus.busy); end
        bus.dec_ready = 1'b1;
        #1;
        total++; if (bus.Read_enable !== 1'b1) begin bad++; $display("FAIL run_resume_re got=%0b exp=1", bus.Read_enable); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.fetch_empty = 1'b0;
        bus.br_valid = 1'b1;
        bus.br_addr  = 32'h0D;
        #1;
        total++; if (bus.Read_enable !== 1'b1) begin bad++; $display("FAIL br_req_cycle_re got=%0b exp=1", bus.Read_enable); end
        tick();
        clear_reqs();
        total++; if (bus.jump_branch_valid !== 1'b1) begin bad++; $display("FAIL br_jbv got=%0b exp=1", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h0D) begin bad++; $display("FAIL br_jba got=%0h exp=d", bus.jump_branch_address); end
        total++; if (bus.flush_out !== 1'b1) begin bad++; $display("FAIL br_flush got=%0b exp=1", bus.flush_out); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL br_busy got=%0b exp=1", bus.busy); end
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL br_redir_re got=%0b exp=0", bus.Read_enable); end
        total++; if (bus.redirect_count !== 16'(STATS)) begin bad++; $display("FAIL br_rcnt got=%0d exp=%0d", bus.redirect_count, STATS); end
        bus.fetch_empty = 1'b1;
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL br_refill_jbv got=%0b exp=0", bus.jump_branch_valid); end
        total++; if (bus.flush_out !== 1'b0) begin bad++; $display("FAIL br_refill_flush got=%0b exp=0", bus.flush_out); end
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL br_refill_re got=%0b exp=0", bus.Read_enable); end
        tick();
        bus.fetch_empty = 1'b0;
        #1;
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL br_exit_re got=%0b exp=0", bus.Read_enable); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL br_exit_busy got=%0b exp=1", bus.busy); end
        tick();
        total++; if (bus.Read_enable !== 1'b1) begin bad++; $display("FAIL br_back_re got=%0b exp=1", bus.Read_enable); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL br_back_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.trap_valid = 1'b1; bus.trap_addr = 32'h100;
        bus.br_valid   = 1'b1; bus.br_addr   = 32'h0D;
        bus.jmp_valid  = 1'b1; bus.jmp_addr  = 32'h09;
        tick();
        clear_reqs();
        total++; if (bus.jump_branch_valid !== 1'b1) begin bad++; $display("FAIL sim_jbv got=%0b exp=1", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h100) begin bad++; $display("FAIL sim_jba got=%0h exp=100", bus.jump_branch_address); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL sim_single[%0d] got=%0b exp=0", i, bus.jump_branch_valid); end
        end
        total++; if (bus.redirect_count !== 16'(STATS)) begin bad++; $display("FAIL sim_rcnt got=%0d exp=%0d", bus.redirect_count, STATS); end
    endtask

    task automatic test_override();
        do_reset();
        bus.br_valid = 1'b1; bus.br_addr = 32'h0D;
        tick();
        clear_reqs();
        tick();
        bus.jmp_valid = 1'b1; bus.jmp_addr = 32'h09;
        tick();
        clear_reqs();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL ovr_jmp_dropped got=%0b exp=0", bus.jump_branch_valid); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%0b exp=1", bus.busy); end
        bus.trap_valid = 1'b1; bus.trap_addr = 32'h100;
        tick();
        clear_reqs();
        total++; if (bus.jump_branch_valid !== 1'b1) begin bad++; $display("FAIL ovr_trap_jbv got=%0b exp=1", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h100) begin bad++; $display("FAIL ovr_trap_jba got=%0h exp=100", bus.jump_branch_address); end
        total++; if (bus.flush_out !== 1'b1) begin bad++; $display("FAIL ovr_trap_flush got=%0b exp=1", bus.flush_out); end
        total++; if (bus.redirect_count !== 16'(2 * STATS)) begin bad++; $display("FAIL ovr_rcnt got=%0d exp=%0d", bus.redirect_count, 2 * STATS); end
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL ovr_after_jbv got=%0b exp=0", bus.jump_branch_valid); end
    endtask

    task automatic test_refill_exit_collision();
        do_reset();
        bus.jmp_valid = 1'b1; bus.jmp_addr = 32'h09;
        tick();
        clear_reqs();
        tick();
        bus.fetch_empty = 1'b0;
        bus.jmp_valid = 1'b1; bus.jmp_addr = 32'h44;
        #1;
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL exit_coll_re got=%0b exp=0", bus.Read_enable); end
        tick();
        clear_reqs();
        total++; if (bus.jump_branch_valid !== 1'b1) begin bad++; $display("FAIL exit_coll_jbv got=%0b exp=1", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h44) begin bad++; $display("FAIL exit_coll_jba got=%0h exp=44", bus.jump_branch_address); end
        total++; if (bus.Read_enable !== 1'b0) begin bad++; $display("FAIL exit_coll_redir_re got=%0b exp=0", bus.Read_enable); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.br_valid = 1'b1; bus.br_addr = 32'h0D;
        tick();
        clear_reqs();
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL to_first_refill got=%0b exp=0", bus.jump_branch_valid); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL to_wait[%0d] got=%0b exp=0", i, bus.jump_branch_valid); end
        end
        tick();
        total++; if (bus.jump_branch_valid !== 1'b1) begin bad++; $display("FAIL to_retry_jbv got=%0b exp=1", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h0D) begin bad++; $display("FAIL to_retry_jba got=%0h exp=d", bus.jump_branch_address); end
        total++; if (bus.retry_count !== 8'(STATS)) begin bad++; $display("FAIL to_retry_cnt got=%0d exp=%0d", bus.retry_count, STATS); end
        total++; if (bus.redirect_count !== 16'(STATS)) begin bad++; $display("FAIL to_rcnt got=%0d exp=%0d", bus.redirect_count, STATS); end
        tick();
        bus.fetch_empty = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_back_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_refill();
        do_reset();
        bus.br_valid = 1'b1; bus.br_addr = 32'h0D;
        tick();
        clear_reqs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_jbv got=%0b exp=0", bus.jump_branch_valid); end
        total++; if (bus.jump_branch_address !== 32'h0) begin bad++; $display("FAIL rst_mid_jba got=%0h exp=0", bus.jump_branch_address); end
        total++; if (bus.flush_out !== 1'b0) begin bad++; $display("FAIL rst_mid_flush got=%0b exp=0", bus.flush_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.redirect_count !== 16'd0) begin bad++; $display("FAIL rst_mid_rcnt got=%0d exp=0", bus.redirect_count); end
        reset = 1'b0;
        bus.fetch_empty = 1'b0;
        tick();
        total++; if (bus.jump_branch_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_nostrobe got=%0b exp=0", bus.jump_branch_valid); end
        total++; if (bus.Read_enable !== 1'b1) begin bad++; $display("FAIL rst_mid_run_re got=%0b exp=1", bus.Read_enable); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_reqs();
        bus.dec_ready   = 1'b0;
        bus.fetch_empty = 1'b1;
        test_reset();
        test_run_stream();
        test_branch();
        test_simultaneous();
        test_override();
        test_refill_exit_collision();
        test_timeout();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Redirect and stall sequencer for the instruction fetch unit. Arbitrates control-flow redirect requests from the trap, branch and jump sources. Drives the fetch unit's single jump/branch port and its Read_enable, and sequences the flush/refill window so decode never receives wrong-path instructions. Sits between the fetch FIFO outputs and the decode/execute stages.

## Interface
- ADDRESS_WIDTH, 32, width of all PC/target addresses
- REFILL_TIMEOUT, 16, max cycles in REFILL before redirect is re-issued; range 2..255
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- trap_valid / trap_addr  in  1 / ADDRESS_WIDTH  trap redirect request + vector
- br_valid / br_addr  in  1 / ADDRESS_WIDTH  taken-branch request + target
- jmp_valid / jmp_addr  in  1 / ADDRESS_WIDTH  jump request + target
- dec_ready  in  1  decode can accept an instruction this cycle
- fetch_empty  in  1  fetch FIFO empty flag
- jump_branch_valid  out  1  one-cycle redirect strobe to fetch
- jump_branch_address  out  ADDRESS_WIDTH  redirect target, valid with strobe
- Read_enable  out  1  pop request to fetch FIFO
- inst_valid  out  1  instruction/PC presented to decode is valid
- flush_out  out  1  kill in-flight decode/execute contents
- busy  out  1  state != RUN
- redirect_count  out  16  accepted redirects (stats)
- retry_count  out  8  timeout re-issues (stats)

## Operation
- States: RUN, REDIRECT, REFILL; encoded state register, reset → RUN.
- Arbitration, fixed priority trap > branch > jump; source code NONE=0, JMP=1, BR=2, TRAP=3.
- RUN: Read_enable = inst_valid = dec_ready & ~fetch_empty (combinational). Any request → latch winner addr/source, go REDIRECT.
- REDIRECT: jump_branch_valid=1, jump_branch_address=latched target, flush_out=1, Read_enable=inst_valid=0; unconditionally → REFILL, refill counter cleared.
- REFILL: Read_enable=inst_valid=0, counter increments. fetch_empty=0 → RUN. Counter reaches REFILL_TIMEOUT with fetch_empty=1 → REDIRECT (same target), retry_count++.
- Request during REDIRECT or REFILL: accepted only if its source code ≥ latched source. Latch updated, next state REDIRECT, i.e. restart. Lower-priority requests are dropped.
- redirect_count increments on every accepted request, including overrides; both counters saturate, never wrap.
- Reset: all outputs 0, latches and counters 0, state RUN; reset in any state aborts the redirect with no strobe emitted.

## Timing
- Request sampled at edge N → jump_branch_valid high for exactly cycle N+1 → REFILL from N+2.
- Minimum redirect bubble: 3 cycles with Read_enable low (REDIRECT + 1 REFILL cycle + fetch refill).
- jump_branch_valid, jump_branch_address, flush_out, busy are registered. Read_enable and inst_valid are combinational from state, dec_ready and fetch_empty.
- Simultaneous requests in one cycle: single strobe, highest-priority address only.
- Request in the same cycle as the REFILL exit (fetch_empty=0) takes precedence → REDIRECT; no pop that cycle.
- dec_ready low in RUN: Read_enable=0, state held; no internal buffering.

## Configuration
- FETCH_REDIRECT_STATS_EN defined: redirect_count and retry_count implemented as specified.
- Undefined: counter logic removed; both ports still present, tied to 0. Redirect behaviour is identical.

## Structure
- Package fetch_ctrl_pkg: state enum (RUN/REDIRECT/REFILL), redirect source enum with the codes above, counter width constants.
- Sub-module redirect_arbiter: combinational three-input priority encoder → {any_valid, source, addr}. Instantiated once.

## Test plan
- Reset then fetch_empty=0, dec_ready=1 → Read_enable=inst_valid=1 every cycle; busy=0, all counters 0.
- br_valid pulse with br_addr=0x0D at edge N → cycle N+1: jump_branch_valid=1, address 0x0D, flush_out=1; Read_enable=0 until fetch_empty drops; redirect_count=1.
- trap 0x100, branch 0x0D, jump 0x09 all in one cycle → single strobe with address 0x100; redirect_count=1.
- In REFILL after branch 0x0D, jmp_valid with 0x09 → dropped, no new strobe. trap_valid with 0x100 → new strobe with 0x100; redirect_count=2.
- REFILL_TIMEOUT=8, fetch_empty held 1 after redirect 0x0D → second strobe with 0x0D 9 cycles after the first REFILL cycle; retry_count=1.
- reset asserted in the middle of REFILL → next cycle state RUN, all outputs 0, no strobe. Macro undefined build → counters read 0 throughout.
